// File: rtl/rns_compare_mrc_seq.sv
// Sequential three-moduli RNS magnitude comparator. Operands are converted to
// mixed-radix digits (d1,d2,d3) over four clocks and the digit tuples compared.
module rns_compare_mrc_seq #(
    parameter int M1    = 9,
    parameter int M2    = 8,
    parameter int M3    = 7,
    parameter int INV12 = 1,
    parameter int INV13 = 4,
    parameter int INV23 = 1
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   start_in,
    input  logic                   mode_signed_in,
    input  logic [$clog2(M1)-1:0]  a1_in,
    input  logic [$clog2(M2)-1:0]  a2_in,
    input  logic [$clog2(M3)-1:0]  a3_in,
    input  logic [$clog2(M1)-1:0]  b1_in,
    input  logic [$clog2(M2)-1:0]  b2_in,
    input  logic [$clog2(M3)-1:0]  b3_in,
    output logic                   ready_out,
    output logic                   done_out,
    output logic                   res_le_out,
    output logic                   res_eq_out,
    output logic                   res_gr_out,
    output logic                   error_out
);

    localparam int W1   = $clog2(M1);
    localparam int W2   = $clog2(M2);
    localparam int W3   = $clog2(M3);
    localparam int WMAX = (W1 > W2) ? ((W1 > W3) ? W1 : W3) : ((W2 > W3) ? W2 : W3);
    localparam int WX   = 2 * WMAX + 1;
    localparam int M    = M1 * M2 * M3;
    localparam int WV   = $clog2(M);
    localparam int HALF = (M + 1) / 2;

    localparam logic [W1:0]   M1_C   = (W1 + 1)'(M1);
    localparam logic [W2:0]   M2_C   = (W2 + 1)'(M2);
    localparam logic [W3:0]   M3_C   = (W3 + 1)'(M3);
    localparam logic [WX-1:0] M2_X   = WX'(M2);
    localparam logic [WX-1:0] M3_X   = WX'(M3);
    localparam logic [WX-1:0] I12_X  = WX'(INV12);
    localparam logic [WX-1:0] I13_X  = WX'(INV13);
    localparam logic [WX-1:0] I23_X  = WX'(INV23);
    localparam logic [WV-1:0] M1_V   = WV'(M1);
    localparam logic [WV-1:0] M12_V  = WV'(M1 * M2);
    localparam logic [WV-1:0] HALF_V = WV'(HALF);

    typedef enum logic [1:0] {IDLE, D2, D3, CMP} state_t;

    state_t          state_q, state_d;
    logic            mode_q, mode_d, err_q, err_d;
    logic [W1-1:0]   a_d1_q, a_d1_d, b_d1_q, b_d1_d;
    logic [W2-1:0]   a_x2_q, a_x2_d, b_x2_q, b_x2_d;
    logic [W3-1:0]   a_x3_q, a_x3_d, b_x3_q, b_x3_d;
    logic [W2-1:0]   a_d2_q, a_d2_d, b_d2_q, b_d2_d;
    logic [W3-1:0]   a_d3_q, a_d3_d, b_d3_q, b_d3_d;
    logic            done_q, done_d, le_q, le_d, eq_q, eq_d, gr_q, gr_d, error_q, error_d;
    logic [WV-1:0]   xa, xb;
    logic            neg_a, neg_b, lt_u, lt;

    // ((x - y) * k) mod m with both operands reduced first; all within WX bits.
    function automatic logic [WX-1:0] sub_mul_mod(input logic [WX-1:0] x, input logic [WX-1:0] y,
                                                  input logic [WX-1:0] m, input logic [WX-1:0] k);
        logic [WX-1:0] xr, yr, diff;
        xr   = x % m;
        yr   = y % m;
        diff = (xr >= yr) ? (xr - yr) : (xr + m - yr);
        return (diff * k) % m;
    endfunction

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        err_d   = err_q;
        a_d1_d  = a_d1_q;  b_d1_d = b_d1_q;
        a_x2_d  = a_x2_q;  b_x2_d = b_x2_q;
        a_x3_d  = a_x3_q;  b_x3_d = b_x3_q;
        a_d2_d  = a_d2_q;  b_d2_d = b_d2_q;
        a_d3_d  = a_d3_q;  b_d3_d = b_d3_q;
        done_d  = 1'b0;
        le_d    = le_q;
        eq_d    = eq_q;
        gr_d    = gr_q;
        error_d = error_q;

        xa    = WV'(a_d1_q) + WV'(a_d2_q) * M1_V + WV'(a_d3_q) * M12_V;
        xb    = WV'(b_d1_q) + WV'(b_d2_q) * M1_V + WV'(b_d3_q) * M12_V;
        neg_a = (xa >= HALF_V);
        neg_b = (xb >= HALF_V);
        lt_u  = {a_d3_q, a_d2_q, a_d1_q} < {b_d3_q, b_d2_q, b_d1_q};
        // Differing signs: the negative operand is smaller regardless of magnitude.
        lt    = (mode_q && (neg_a != neg_b)) ? neg_a : lt_u;

        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    mode_d  = mode_signed_in;
                    a_d1_d  = a1_in;  b_d1_d = b1_in;
                    a_x2_d  = a2_in;  b_x2_d = b2_in;
                    a_x3_d  = a3_in;  b_x3_d = b3_in;
                    err_d   = ({1'b0, a1_in} >= M1_C) || ({1'b0, b1_in} >= M1_C) ||
                              ({1'b0, a2_in} >= M2_C) || ({1'b0, b2_in} >= M2_C) ||
                              ({1'b0, a3_in} >= M3_C) || ({1'b0, b3_in} >= M3_C);
                    state_d = D2;
                end
            end
            D2: begin
                a_d2_d  = W2'(sub_mul_mod(WX'(a_x2_q), WX'(a_d1_q), M2_X, I12_X));
                b_d2_d  = W2'(sub_mul_mod(WX'(b_x2_q), WX'(b_d1_q), M2_X, I12_X));
                state_d = D3;
            end
            D3: begin
                a_d3_d  = W3'(sub_mul_mod(sub_mul_mod(WX'(a_x3_q), WX'(a_d1_q), M3_X, I13_X),
                                          WX'(a_d2_q), M3_X, I23_X));
                b_d3_d  = W3'(sub_mul_mod(sub_mul_mod(WX'(b_x3_q), WX'(b_d1_q), M3_X, I13_X),
                                          WX'(b_d2_q), M3_X, I23_X));
                state_d = CMP;
            end
            CMP: begin
                error_d = err_q;
                eq_d    = !err_q && ({a_d3_q, a_d2_q, a_d1_q} == {b_d3_q, b_d2_q, b_d1_q});
                le_d    = !err_q && !eq_d && lt;
                gr_d    = !err_q && !eq_d && !lt;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
            a_d1_q  <= '0;  b_d1_q <= '0;
            a_x2_q  <= '0;  b_x2_q <= '0;
            a_x3_q  <= '0;  b_x3_q <= '0;
            a_d2_q  <= '0;  b_d2_q <= '0;
            a_d3_q  <= '0;  b_d3_q <= '0;
            done_q  <= 1'b0;
            le_q    <= 1'b0;
            eq_q    <= 1'b0;
            gr_q    <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            a_d1_q  <= a_d1_d;  b_d1_q <= b_d1_d;
            a_x2_q  <= a_x2_d;  b_x2_q <= b_x2_d;
            a_x3_q  <= a_x3_d;  b_x3_q <= b_x3_d;
            a_d2_q  <= a_d2_d;  b_d2_q <= b_d2_d;
            a_d3_q  <= a_d3_d;  b_d3_q <= b_d3_d;
            done_q  <= done_d;
            le_q    <= le_d;
            eq_q    <= eq_d;
            gr_q    <= gr_d;
            error_q <= error_d;
        end
    end

    assign ready_out  = (state_q == IDLE);
    assign done_out   = done_q;
    assign res_le_out = le_q;
    assign res_eq_out = eq_q;
    assign res_gr_out = gr_q;
    assign error_out  = error_q;

endmodule

// File: doc/rns_compare_mrc_seq.md
Name: rns_compare_mrc_seq

Overview:
- Sequential, parametrised successor to the combinational three-moduli RNS comparator.
- Compares two RNS operands A and B over a configurable co-prime set {M1,M2,M3} using iterative mixed-radix conversion (MRC); no full CRT reverse converter is needed.
- Adds a start/ready/done handshake, a selectable signed (symmetric-range) comparison mode and detection of invalid residues.
- Sits between RNS datapath units and control logic that needs ordering decisions (sign detection, overflow checks, max/min).

Parameters:
M1, 9, first modulus; the MRC base digit.
M2, 8, second modulus.
M3, 7, third modulus.
INV12, 1, multiplicative inverse of (M1 mod M2) modulo M2.
INV13, 4, multiplicative inverse of (M1 mod M3) modulo M3.
INV23, 1, multiplicative inverse of (M2 mod M3) modulo M3.
Derived, not overridable: Wi = clog2(Mi); M = M1*M2*M3; HALF = (M+1)/2.

Ports:
clk_in  input  1  clock; all state updates on the rising edge
rst_n_in  input  1  asynchronous active-low reset
start_in  input  1  request; accepted on a rising edge where ready_out=1
mode_signed_in  input  1  0 = unsigned range [0,M); 1 = signed, with X >= HALF meaning X-M; sampled at accept
a1_in/a2_in/a3_in  input  W1/W2/W3  residues of A
b1_in/b2_in/b3_in  input  W1/W2/W3  residues of B
ready_out  output  1  high while the FSM is in IDLE
done_out  output  1  one-cycle pulse when the result is valid
res_le_out  output  1  A < B
res_eq_out  output  1  A == B
res_gr_out  output  1  A > B
error_out  output  1  a residue in the accepted operands was >= its modulus

Behaviour:
- Reset (asynchronous, any time, including mid-operation): FSM goes to IDLE; ready_out=1; done_out, res_*_out and error_out all 0. The operation in flight is discarded.
- FSM states: IDLE -> D2 -> D3 -> CMP -> IDLE.
- IDLE: on start_in=1, register all six residues and the mode, set d1 = x1 for each operand, and go to D2. When start_in=0, remain in IDLE.
- D2: compute d2 = ((x2 - d1 mod M2) * INV12) mod M2 for A and B in parallel. Go to D3.
- D3: compute d3 = (((x3 - d1 mod M3) * INV13 - d2 mod M3) * INV23) mod M3 for A and B in parallel. Go to CMP.
- CMP: evaluate the flags, register them, pulse done_out, and return to IDLE.
- Modular subtraction: add the modulus when the difference is negative. Products must be reduced into [0,Mi) within the same cycle. Intermediate width is at most 2*max(Wi)+1.
- Value reconstruction: X = d1 + d2*M1 + d3*M1*M2, with width clog2(M).
- Unsigned mode: compare the digit tuples (d3,d2,d1) lexicographically, most significant digit first.
- Signed mode: neg = (X >= HALF).
  - If the signs differ, the negative operand is the smaller one.
  - If the signs match, use the unsigned ordering.
- Exactly one of res_le_out, res_eq_out, res_gr_out is 1 after a valid compare.
- Results and error_out hold their values until the next accepted start. They are not cleared when the next compare is accepted.
- Timing: with the accept edge as E0, done_out=1 in the cycle following E3. Latency is 4 clocks. Throughput is one compare per 4 clocks.
- Back-to-back operation: done_out and ready_out are high in the same cycle, so a start in that cycle is accepted.
- start_in while ready_out=0 is ignored. It is not queued.
- Invalid operand (any ai >= Mi or bi >= Mi at accept): error_out=1 and all three res flags are 0 at done. Timing is unchanged.
- Inputs change after the accept edge: no effect on the operation in flight.

Test Plan:
- Reset mid-D3 (assert rst_n_in=0 for 1 cycle) -> ready_out=1 and all other outputs 0 immediately, without waiting for a clock edge; the next compare completes normally.
- Unsigned sweep: A=i, B=503-i for i=0..503, residues (i%9, i%8, i%7) -> flags match the integer compare; each done_out occurs exactly 4 clocks after accept.
- A=100 (1,4,2) vs B=200 (2,0,4), unsigned -> le=1, eq=0, gr=0; internal digits of A are d1=1, d2=3, d3=1.
- A=300 (3,4,6) vs B=5 (5,5,5): unsigned -> gr=1; signed -> le=1 (A = -204). A=503 (8,7,6) vs B=0 signed -> le=1. A=B=251 signed -> eq=1.
- a1_in=9 (invalid), any B -> error_out=1, res flags all 0; the next valid request clears error_out.
- Back-to-back: start held high for 12 cycles -> 3 accepted compares with done pulses 4 cycles apart; a start pulse while busy is ignored and produces no extra done_out.
